// File: rtl/regfile_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | regfile_seq: serial operand-fetch / ALU / writeback command sequencer.   |
// | Optional: REGFILE_SEQ_FLAGS_EN adds the {N,Z,V} flags output.  Rev 1.0   |
// +-------------------------------------------------------------------------+
module regfile_seq #(
   parameter int DW   = 16,
   parameter int AW   = 3,
   parameter int IMMW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [1:0]      cmd_fn,
   input  logic [AW-1:0]   cmd_rd,
   input  logic [AW-1:0]   cmd_rs1,
   input  logic [AW-1:0]   cmd_rs2,
   input  logic [IMMW-1:0] cmd_imm,
   output logic [AW-1:0]   rf_readnum,
   input  logic [DW-1:0]   rf_data_out,
   output logic [AW-1:0]   rf_writenum,
   output logic            rf_write,
   output logic [DW-1:0]   rf_data_in,
   output logic [DW-1:0]   alu_a,
   output logic [DW-1:0]   alu_b,
   output logic [1:0]      alu_fn,
   input  logic [DW-1:0]   alu_result,
   output logic            done,
   output logic            busy
`ifdef REGFILE_SEQ_FLAGS_EN
   ,
   output logic [2:0]      flags
`endif
);

   localparam logic [1:0] OP_ALU  = 2'b00;
   localparam logic [1:0] OP_MOVI = 2'b01;
   localparam logic [1:0] OP_MOV  = 2'b10;
   localparam logic [1:0] OP_CMP  = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOADA = 3'd1,
      LOADB = 3'd2,
      EXEC  = 3'd3,
      WRITE = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [DW-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
   logic [1:0]     fn_q, fn_d, op_q, op_d;
   logic [AW-1:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [AW-1:0]  readnum_q, readnum_d;
`ifdef REGFILE_SEQ_FLAGS_EN
   logic [2:0]     flags_q, flags_d;
   logic [DW-1:0]  sum_ab;
   assign sum_ab = a_q + b_q;
`endif

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      fn_d      = fn_q;
      op_d      = op_q;
      rd_d      = rd_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      readnum_d = readnum_q;
`ifdef REGFILE_SEQ_FLAGS_EN
      flags_d   = flags_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               fn_d  = cmd_fn;
               op_d  = cmd_op;
               rd_d  = cmd_rd;
               rs1_d = cmd_rs1;
               rs2_d = cmd_rs2;
               if (cmd_op == OP_MOVI) begin
                  c_d     = {{(DW-IMMW){cmd_imm[IMMW-1]}}, cmd_imm};
                  state_d = WRITE;
               end else begin
                  state_d = LOADA;
               end
            end
         end
         LOADA: begin
            readnum_d = rs1_q;
            a_d       = rf_data_out;
            if (op_q == OP_MOV) begin
               c_d     = rf_data_out;
               state_d = WRITE;
            end else begin
               state_d = LOADB;
            end
         end
         LOADB: begin
            readnum_d = rs2_q;
            b_d       = rf_data_out;
            state_d   = EXEC;
         end
         EXEC: begin
            c_d = alu_result;
`ifdef REGFILE_SEQ_FLAGS_EN
            // V is the add overflow of the latched operands, whatever fn selects
            flags_d = {alu_result[DW-1], (alu_result == '0),
                       (a_q[DW-1] == b_q[DW-1]) && (sum_ab[DW-1] != a_q[DW-1])};
`endif
            state_d = (op_q == OP_CMP) ? IDLE : WRITE;
         end
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         fn_q      <= '0;
         op_q      <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         readnum_q <= '0;
`ifdef REGFILE_SEQ_FLAGS_EN
         flags_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
         fn_q      <= fn_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         readnum_q <= readnum_d;
`ifdef REGFILE_SEQ_FLAGS_EN
         flags_q   <= flags_d;
`endif
      end
   end

   // The regfile has no reset, so a write must be masked the moment rst_n drops
   assign rf_write    = (state_q == WRITE) && rst_n;
   assign done        = rst_n && ((state_q == WRITE) ||
                                  ((state_q == EXEC) && (op_q == OP_CMP)));
   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign rf_readnum  = readnum_d;
   assign rf_writenum = rd_q;
   assign rf_data_in  = c_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_fn      = fn_q;
`ifdef REGFILE_SEQ_FLAGS_EN
   assign flags       = flags_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_seq.sv
`default_nettype none
// Bench for regfile_seq with a behavioural 8x16 regfile and 4-function ALU.
module tb_regfile_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0, cmd_fn = '0;
   logic [2:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
   logic [7:0]  cmd_imm = '0;
   logic [2:0]  rf_readnum, rf_writenum;
   logic [15:0] rf_data_out, rf_data_in, alu_a, alu_b, alu_result;
   logic        rf_write, done, busy;
   logic [1:0]  alu_fn;
`ifdef REGFILE_SEQ_FLAGS_EN
   logic [2:0]  flags;
`endif

   logic [15:0] rf [8];
   logic        bd_we = 1'b0;
   logic [2:0]  bd_addr = '0;
   logic [15:0] bd_data = '0;

   int checks = 0;
   int errors = 0;

   // task outputs
   int          lat;
   logic        saw_wr, d_wr;
   logic [2:0]  rn1, rn2, rnd, d_wn;
   logic [15:0] d_wd, d_aa, d_ab;
   int          ready_hi;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rf_write) rf[rf_writenum] <= rf_data_in;
      if (bd_we)    rf[bd_addr]     <= bd_data;
   end
   assign rf_data_out = rf[rf_readnum];

   always_comb begin
      alu_result = '0;
      case (alu_fn)
         2'b00: alu_result = alu_a + alu_b;
         2'b01: alu_result = alu_a - alu_b;
         2'b10: alu_result = alu_a & alu_b;
         2'b11: alu_result = alu_a | alu_b;
         default: alu_result = '0;
      endcase
   end

   regfile_seq dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_fn(cmd_fn), .cmd_rd(cmd_rd),
      .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
      .rf_readnum(rf_readnum), .rf_data_out(rf_data_out),
      .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_result(alu_result),
      .done(done), .busy(busy)
`ifdef REGFILE_SEQ_FLAGS_EN
      , .flags(flags)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bd_write(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [1:0] fn, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm);
      @(negedge clk);
      cmd_op = op; cmd_fn = fn; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 0; saw_wr = 1'b0;
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         @(negedge clk);
         if (k == 1) rn1 = rf_readnum;
         if (k == 2) rn2 = rf_readnum;
         if (rf_write) saw_wr = 1'b1;
         if (done) begin
            lat = k; d_wr = rf_write; d_wn = rf_writenum; d_wd = rf_data_in;
            d_aa = alu_a; d_ab = alu_b; rnd = rf_readnum;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      // reset held
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_write", 32'(rf_write), 32'd0);
      check("rst_readnum", 32'(rf_readnum), 32'd0);
      check("rst_writenum", 32'(rf_writenum), 32'd0);
      check("rst_data_in", 32'(rf_data_in), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      check("rst_alu_fn", 32'(alu_fn), 32'd0);
`ifdef REGFILE_SEQ_FLAGS_EN
      check("rst_flags", 32'(flags), 32'd0);
`endif
      rst_n = 1'b1;

      // MOVI R3 = sext(F6)
      run_cmd(2'b01, 2'b00, 3'd3, 3'd0, 3'd0, 8'hF6);
      check("movi_lat", 32'(lat), 32'd1);
      check("movi_wr", 32'(d_wr), 32'd1);
      check("movi_wn", 32'(d_wn), 32'd3);
      check("movi_wd", 32'(d_wd), 32'h0000FFF6);
      check("movi_r3", 32'(rf[3]), 32'h0000FFF6);

      // R1=5, R2=3, ALU add -> R4
      run_cmd(2'b01, 2'b00, 3'd1, 3'd0, 3'd0, 8'h05);
      check("movi_r1_lat", 32'(lat), 32'd1);
      run_cmd(2'b01, 2'b00, 3'd2, 3'd0, 3'd0, 8'h03);
      check("movi_r2_lat", 32'(lat), 32'd1);
      run_cmd(2'b00, 2'b00, 3'd4, 3'd1, 3'd2, 8'h00);
      check("alu_lat", 32'(lat), 32'd4);
      check("alu_rn1", 32'(rn1), 32'd1);
      check("alu_rn2", 32'(rn2), 32'd2);
      check("alu_rn_hold", 32'(rnd), 32'd2);
      check("alu_a", 32'(d_aa), 32'd5);
      check("alu_b", 32'(d_ab), 32'd3);
      check("alu_wd", 32'(d_wd), 32'd8);
      check("alu_r4", 32'(rf[4]), 32'd8);

      // aliasing: R1 = R1 + R1 with R1 = 4, then MOV R7 = R1
      run_cmd(2'b01, 2'b00, 3'd1, 3'd0, 3'd0, 8'h04);
      run_cmd(2'b00, 2'b00, 3'd1, 3'd1, 3'd1, 8'h00);
      check("alias_lat", 32'(lat), 32'd4);
      check("alias_r1", 32'(rf[1]), 32'd8);
      run_cmd(2'b10, 2'b00, 3'd7, 3'd1, 3'd0, 8'h00);
      check("mov_lat", 32'(lat), 32'd2);
      check("mov_r7", 32'(rf[7]), 32'd8);

      // CMP R1 - R2 with both 1234: no write
      bd_write(3'd1, 16'h1234);
      bd_write(3'd2, 16'h1234);
      bd_write(3'd5, 16'h0000);
      run_cmd(2'b11, 2'b01, 3'd5, 3'd1, 3'd2, 8'h00);
      check("cmp_lat", 32'(lat), 32'd3);
      check("cmp_no_write", 32'(saw_wr), 32'd0);
      check("cmp_r5", 32'(rf[5]), 32'd0);
`ifdef REGFILE_SEQ_FLAGS_EN
      check("cmp_flags", 32'(flags), 32'b010);
`endif

      // cmd_valid held through a busy ALU command: R6 = R4 + R4 = 16
      @(negedge clk);
      cmd_op = 2'b00; cmd_fn = 2'b00; cmd_rd = 3'd6; cmd_rs1 = 3'd4; cmd_rs2 = 3'd4;
      cmd_valid = 1'b1;
      ready_hi = 0; lat = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (cmd_ready) ready_hi++;
         if (done && lat == 0) lat = k;
      end
      check("hold_ready_low", 32'(ready_hi), 32'd0);
      check("hold_lat", 32'(lat), 32'd4);
      @(negedge clk);
      check("hold_ready_back", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("hold_busy", 32'(busy), 32'd0);
      check("hold_r6", 32'(rf[6]), 32'h10);

      // reset asserted in the WRITE cycle of MOVI R2
      @(negedge clk);
      cmd_op = 2'b01; cmd_rd = 3'd2; cmd_imm = 8'h7F; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstw_write", 32'(rf_write), 32'd0);
      check("rstw_done", 32'(done), 32'd0);
      @(negedge clk);
      check("rstw_r2", 32'(rf[2]), 32'h1234);
      check("rstw_ready", 32'(cmd_ready), 32'd1);
      check("rstw_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
